vga_frame_regs: RTL and testbench

- Avalon-MM register front end that sits directly upstream of the VGA raster/sprite stage.
- HPS writes land in a shadow bank. The active bank, which drives the raster stage's boundary and sprite inputs, updates atomically at the start of vertical blank, so there is no mid-frame tearing.
- Also provides a frame counter, a commit-pending status bit and a vblank interrupt so software can pace game updates to the display.

---
 rtl/vga_frame_regs.sv | 240 ++++++++++++++++++++++++
 tb/tb_vga_frame_regs.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_regs.sv
// vga_frame_regs: Avalon-MM register front end for the VGA raster/sprite stage.
// Software writes a shadow bank. The active bank that drives the raster stage
// is loaded from the shadow bank only at the start of vertical blank, so a
// frame is never drawn with a mix of old and new values. A frame counter, a
// commit-pending flag and a sticky vblank interrupt let software pace its
// updates to the display.

module vga_frame_regs #(
    parameter int VACTIVE  = 480,  // first non-visible line; the vblank event fires here
    parameter int FCOUNT_W = 16    // frame counter width, at most 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [5:0]  address,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    output logic [9:0]  boundary_1,
    output logic [9:0]  boundary_2,
    output logic [9:0]  boundary_3,
    output logic [9:0]  boundary_4,
    output logic [9:0]  sprite1_x,
    output logic [9:0]  sprite1_y,
    output logic [4:0]  sprite1_img
);

    // ------------------------------------------------------------------
    // Register map (word addresses)
    // ------------------------------------------------------------------
    localparam logic [5:0] ADDR_BOUNDARY_1 = 6'h00;
    localparam logic [5:0] ADDR_BOUNDARY_2 = 6'h01;
    localparam logic [5:0] ADDR_BOUNDARY_3 = 6'h02;
    localparam logic [5:0] ADDR_BOUNDARY_4 = 6'h03;
    localparam logic [5:0] ADDR_SPRITE_X   = 6'h04;
    localparam logic [5:0] ADDR_SPRITE_Y   = 6'h05;
    localparam logic [5:0] ADDR_SPRITE_IMG = 6'h06;
    localparam logic [5:0] ADDR_CTRL       = 6'h07;
    localparam logic [5:0] ADDR_FRAME      = 6'h08;
    localparam logic [5:0] ADDR_IRQ_ACK    = 6'h09;

    // Line on which the vblank event is detected.
    localparam logic [9:0] VBLANK_LINE = 10'(VACTIVE);

    // One complete set of raster parameters. The same layout is used for the
    // shadow bank (software view) and the active bank (raster view), so a
    // commit is a single whole-struct copy.
    typedef struct packed {
        logic [9:0] boundary_1;
        logic [9:0] boundary_2;
        logic [9:0] boundary_3;
        logic [9:0] boundary_4;
        logic [9:0] sprite_x;
        logic [9:0] sprite_y;    // bit0 = sprite visible
        logic [4:0] sprite_img;
    } bank_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    bank_t                shadow_q,   shadow_d;
    bank_t                active_q,   active_d;
    logic                 pending_q,  pending_d;
    logic                 auto_q,     auto_d;
    logic                 irq_en_q,   irq_en_d;
    logic                 irq_q,      irq_d;
    logic [FCOUNT_W-1:0]  frame_q,    frame_d;
    logic [15:0]          readdata_q, readdata_d;
    logic                 match_q,    match_d;
    logic                 vb_q,       vb_d;

    // Bus strobes and the commit decision for this cycle.
    logic bus_wr;
    logic bus_rd;
    logic commit;

    // Field bits above 9:0 never reach a register; gathering them here keeps
    // the intent visible instead of leaving the bits silently dangling.
    logic unused_writedata;
    assign unused_writedata = &{1'b0, writedata[15:10]};

    assign bus_wr = chipselect && write;
    assign bus_rd = chipselect && read;

    // A commit uses the flags and shadow values as they stood before this
    // edge, so a same-cycle CTRL or shadow write only affects the next frame.
    assign commit = vb_q && (pending_q || auto_q);

    // ------------------------------------------------------------------
    // Vblank detection: registered single-cycle pulse on the first cycle
    // the raster sits at (VACTIVE, 0). The edge detect keeps it to one pulse
    // per frame even if hcount holds 0 for several clocks.
    // ------------------------------------------------------------------
    always_comb begin
        match_d = (vcount == VBLANK_LINE) && (hcount == 11'd0);
        vb_d    = match_d && !match_q;
    end

    // ------------------------------------------------------------------
    // Shadow bank: software writes, zero-width fields above each register
    // are dropped.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a full default first, so no path
        // through the case statements can leave it unassigned and infer a latch.
        shadow_d = shadow_q;
        if (bus_wr) begin
            unique case (address)
                ADDR_BOUNDARY_1: shadow_d.boundary_1 = writedata[9:0];
                ADDR_BOUNDARY_2: shadow_d.boundary_2 = writedata[9:0];
                ADDR_BOUNDARY_3: shadow_d.boundary_3 = writedata[9:0];
                ADDR_BOUNDARY_4: shadow_d.boundary_4 = writedata[9:0];
                ADDR_SPRITE_X:   shadow_d.sprite_x   = writedata[9:0];
                ADDR_SPRITE_Y:   shadow_d.sprite_y   = writedata[9:0];
                ADDR_SPRITE_IMG: shadow_d.sprite_img = writedata[4:0];
                default:         ;
            endcase
        end
    end

    // Active bank: loads the whole shadow bank on a commit, otherwise holds.
    always_comb begin
        active_d = commit ? shadow_q : active_q;
    end

    // ------------------------------------------------------------------
    // Control flags. Pending is cleared by a commit but a CTRL bit0 write in
    // the same cycle re-arms it, so the later assignment wins.
    // ------------------------------------------------------------------
    always_comb begin
        pending_d = pending_q;
        auto_d    = auto_q;
        irq_en_d  = irq_en_q;
        if (commit) begin
            pending_d = 1'b0;
        end
        if (bus_wr && address == ADDR_CTRL) begin
            auto_d   = writedata[1];
            irq_en_d = writedata[2];
            if (writedata[0]) begin
                pending_d = 1'b1;
            end
        end
    end

    // Sticky interrupt: acknowledge clears it, a vblank with irq_en set sets
    // it, and the set is applied last so it wins a same-cycle acknowledge.
    always_comb begin
        irq_d = irq_q;
        if (bus_wr && address == ADDR_IRQ_ACK) begin
            irq_d = 1'b0;
        end
        if (vb_q && irq_en_q) begin
            irq_d = 1'b1;
        end
    end

    // Frame counter: one increment per vblank, wrapping naturally at its width.
    always_comb begin
        frame_d = frame_q;
        if (vb_q) begin
            frame_d = frame_q + FCOUNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Read data: latency 1, holds its last value when no read is issued.
    // Shadow registers read back the shadow value, not the active one.
    // ------------------------------------------------------------------
    always_comb begin
        readdata_d = readdata_q;
        if (bus_rd) begin
            unique case (address)
                ADDR_BOUNDARY_1: readdata_d = 16'(shadow_q.boundary_1);
                ADDR_BOUNDARY_2: readdata_d = 16'(shadow_q.boundary_2);
                ADDR_BOUNDARY_3: readdata_d = 16'(shadow_q.boundary_3);
                ADDR_BOUNDARY_4: readdata_d = 16'(shadow_q.boundary_4);
                ADDR_SPRITE_X:   readdata_d = 16'(shadow_q.sprite_x);
                ADDR_SPRITE_Y:   readdata_d = 16'(shadow_q.sprite_y);
                ADDR_SPRITE_IMG: readdata_d = 16'(shadow_q.sprite_img);
                ADDR_CTRL:       readdata_d = {13'd0, irq_en_q, auto_q, pending_q};
                ADDR_FRAME:      readdata_d = 16'(frame_q);
                default:         readdata_d = 16'd0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // All state registers, cleared together by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: every register here, including both register banks, is reset
        // so the sprite comes up hidden and no stale commit survives a reset.
        if (reset) begin
            shadow_q   <= '0;
            active_q   <= '0;
            pending_q  <= 1'b0;
            auto_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
            frame_q    <= '0;
            readdata_q <= 16'd0;
            match_q    <= 1'b0;
            vb_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // pre-edge values; this is what makes same-cycle write/commit
            // ordering well defined.
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            auto_q     <= auto_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
            frame_q    <= frame_d;
            readdata_q <= readdata_d;
            match_q    <= match_d;
            vb_q       <= vb_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign readdata    = readdata_q;
    assign irq         = irq_q;
    assign boundary_1  = active_q.boundary_1;
    assign boundary_2  = active_q.boundary_2;
    assign boundary_3  = active_q.boundary_3;
    assign boundary_4  = active_q.boundary_4;
    assign sprite1_x   = active_q.sprite_x;
    assign sprite1_y   = active_q.sprite_y;
    assign sprite1_img = active_q.sprite_img;

endmodule

// File: tb/tb_vga_frame_regs.sv
// tb_vga_frame_regs: directed bench for vga_frame_regs. The raster position is
// driven directly, so a "frame" is just a visit to (480, 0). A second instance
// with a 4-bit frame counter exercises the counter wrap in a handful of frames.

module tb_vga_frame_regs;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [5:0]  address = 6'd0;
    logic [15:0] writedata = 16'd0;
    logic [10:0] hcount = 11'd0;
    logic [9:0]  vcount = 10'd0;

    logic [15:0] readdata;
    logic        irq;
    logic [9:0]  boundary_1, boundary_2, boundary_3, boundary_4;
    logic [9:0]  sprite1_x, sprite1_y;
    logic [4:0]  sprite1_img;

    logic [15:0] readdata_w;
    logic        irq_w;
    logic [9:0]  b1_w, b2_w, b3_w, b4_w, sx_w, sy_w;
    logic [4:0]  img_w;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    vga_frame_regs #(.VACTIVE(480), .FCOUNT_W(16)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
        .read(read), .address(address), .writedata(writedata),
        .readdata(readdata), .irq(irq), .hcount(hcount), .vcount(vcount),
        .boundary_1(boundary_1), .boundary_2(boundary_2),
        .boundary_3(boundary_3), .boundary_4(boundary_4),
        .sprite1_x(sprite1_x), .sprite1_y(sprite1_y), .sprite1_img(sprite1_img)
    );

    vga_frame_regs #(.VACTIVE(480), .FCOUNT_W(4)) dut_w (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
        .read(read), .address(address), .writedata(writedata),
        .readdata(readdata_w), .irq(irq_w), .hcount(hcount), .vcount(vcount),
        .boundary_1(b1_w), .boundary_2(b2_w), .boundary_3(b3_w), .boundary_4(b4_w),
        .sprite1_x(sx_w), .sprite1_y(sy_w), .sprite1_img(img_w)
    );

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic raster_idle();
        vcount = 10'd100;
        hcount = 11'd5;
    endtask

    task automatic avl_write(input logic [5:0] a, input logic [15:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write = 1'b0; address = 6'd0; writedata = 16'd0;
    endtask

    task automatic avl_read(input logic [5:0] a, output logic [15:0] d);
        chipselect = 1'b1; read = 1'b1; address = a;
        tick();
        chipselect = 1'b0; read = 1'b0; address = 6'd0;
        d = readdata;
    endtask

    // Presents (480, 0) for one edge; returns inside the vb cycle.
    task automatic vb_start();
        vcount = 10'd480;
        hcount = 11'd0;
        tick();
        hcount = 11'd1;
    endtask

    task automatic run_frame();
        vb_start();
        tick();
        raster_idle();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        raster_idle();
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [15:0] d;
        #5;
        checks++; if ({boundary_1, boundary_2, boundary_3, boundary_4, sprite1_x, sprite1_y, sprite1_img} !== 65'd0) begin errors++; $display("FAIL reset_outputs: got %h exp 0", {boundary_1, boundary_2, boundary_3, boundary_4, sprite1_x, sprite1_y, sprite1_img}); end
        checks++; if (readdata !== 16'h0000) begin errors++; $display("FAIL reset_readdata: got %h exp 0000", readdata); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b exp 0", irq); end
        tick();
        reset = 1'b0;
        raster_idle();
        tick();
        avl_read(6'h08, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_frame: got %h exp 0000", d); end
    endtask

    task automatic test_commit();
        logic [15:0] d;
        avl_write(6'h00, 16'd120);
        avl_write(6'h01, 16'd200);
        avl_write(6'h07, 16'h0001);
        avl_read(6'h07, d);
        checks++; if (d !== 16'h0001) begin errors++; $display("FAIL commit_pending_set: got %h exp 0001", d); end
        checks++; if (boundary_1 !== 10'd0) begin errors++; $display("FAIL commit_b1_midframe: got %0d exp 0", boundary_1); end
        vb_start();
        checks++; if (boundary_1 !== 10'd0) begin errors++; $display("FAIL commit_b1_vbcycle: got %0d exp 0", boundary_1); end
        tick();
        checks++; if (boundary_1 !== 10'd120 || boundary_2 !== 10'd200) begin errors++; $display("FAIL commit_b1_b2: got %0d/%0d exp 120/200", boundary_1, boundary_2); end
        checks++; if (boundary_3 !== 10'd0) begin errors++; $display("FAIL commit_b3: got %0d exp 0", boundary_3); end
        raster_idle();
        avl_read(6'h07, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL commit_pending_clear: got %h exp 0000", d); end
        avl_read(6'h00, d);
        checks++; if (d !== 16'd120) begin errors++; $display("FAIL commit_shadow_read: got %0d exp 120", d); end
        tick();
        checks++; if (readdata !== 16'd120) begin errors++; $display("FAIL readdata_hold: got %0d exp 120", readdata); end
    endtask

    task automatic test_auto();
        logic [15:0] d;
        avl_write(6'h07, 16'h0002);
        avl_write(6'h04, 16'd37);
        tick(); tick();
        checks++; if (sprite1_x !== 10'd0) begin errors++; $display("FAIL auto_x_early: got %0d exp 0", sprite1_x); end
        vb_start();
        checks++; if (sprite1_x !== 10'd0) begin errors++; $display("FAIL auto_x_vbcycle: got %0d exp 0", sprite1_x); end
        tick();
        raster_idle();
        checks++; if (sprite1_x !== 10'd37) begin errors++; $display("FAIL auto_x_commit: got %0d exp 37", sprite1_x); end
        // shadow write landing on the vb edge: active takes the old shadow
        vb_start();
        avl_write(6'h04, 16'd55);
        raster_idle();
        checks++; if (sprite1_x !== 10'd37) begin errors++; $display("FAIL auto_x_vbwrite: got %0d exp 37", sprite1_x); end
        avl_read(6'h04, d);
        checks++; if (d !== 16'd55) begin errors++; $display("FAIL auto_x_shadow: got %0d exp 55", d); end
        avl_write(6'h05, 16'hFC01);
        avl_write(6'h06, 16'hFFEA);
        run_frame();
        checks++; if (sprite1_x !== 10'd55) begin errors++; $display("FAIL auto_x_next: got %0d exp 55", sprite1_x); end
        checks++; if (sprite1_y !== 10'd1 || sprite1_img !== 5'd10) begin errors++; $display("FAIL auto_y_img: got %0d/%0d exp 1/10", sprite1_y, sprite1_img); end
        avl_read(6'h05, d);
        checks++; if (d !== 16'h0001) begin errors++; $display("FAIL field_trunc_y: got %h exp 0001", d); end
        avl_read(6'h06, d);
        checks++; if (d !== 16'h000A) begin errors++; $display("FAIL field_trunc_img: got %h exp 000a", d); end
        avl_write(6'h07, 16'h0000);
    endtask

    task automatic test_irq();
        logic [15:0] d;
        apply_reset();
        avl_write(6'h07, 16'h0004);
        avl_read(6'h07, d);
        checks++; if (d !== 16'h0004) begin errors++; $display("FAIL irq_ctrl_read: got %h exp 0004", d); end
        vb_start();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_before_vb: got %b exp 0", irq); end
        tick();
        raster_idle();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_frame1: got %b exp 1", irq); end
        avl_write(6'h09, 16'h0000);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_ack: got %b exp 0", irq); end
        avl_read(6'h09, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL irq_ack_read: got %h exp 0000", d); end
        run_frame();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_frame2: got %b exp 1", irq); end
        vb_start();
        avl_write(6'h09, 16'h0000);
        raster_idle();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins: got %b exp 1", irq); end
        avl_read(6'h08, d);
        checks++; if (d !== 16'd3) begin errors++; $display("FAIL irq_frame_count: got %0d exp 3", d); end
        avl_write(6'h07, 16'h0000);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_en_clear_keeps: got %b exp 1", irq); end
        avl_write(6'h09, 16'h0000);
        run_frame();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_disabled: got %b exp 0", irq); end
        avl_read(6'h08, d);
        checks++; if (d !== 16'd4) begin errors++; $display("FAIL irq_frame_count4: got %0d exp 4", d); end
    endtask

    task automatic test_one_vb_per_frame();
        logic [15:0] d;
        vcount = 10'd480;
        hcount = 11'd0;
        tick(); tick(); tick();
        raster_idle();
        tick();
        avl_read(6'h08, d);
        checks++; if (d !== 16'd5) begin errors++; $display("FAIL single_vb: got %0d exp 5", d); end
    endtask

    task automatic test_pending_on_vb();
        logic [15:0] d;
        avl_write(6'h02, 16'd77);
        vb_start();
        avl_write(6'h07, 16'h0001);
        raster_idle();
        checks++; if (boundary_3 !== 10'd0) begin errors++; $display("FAIL vbctrl_no_commit: got %0d exp 0", boundary_3); end
        avl_read(6'h07, d);
        checks++; if (d !== 16'h0001) begin errors++; $display("FAIL vbctrl_pending: got %h exp 0001", d); end
        run_frame();
        checks++; if (boundary_3 !== 10'd77) begin errors++; $display("FAIL vbctrl_commit: got %0d exp 77", boundary_3); end
        // pending already set and re-armed on the vb edge: commit and stay pending
        avl_write(6'h03, 16'd99);
        avl_write(6'h07, 16'h0001);
        vb_start();
        avl_write(6'h07, 16'h0001);
        raster_idle();
        checks++; if (boundary_4 !== 10'd99) begin errors++; $display("FAIL vbctrl_rearm_commit: got %0d exp 99", boundary_4); end
        avl_read(6'h07, d);
        checks++; if (d !== 16'h0001) begin errors++; $display("FAIL vbctrl_rearm_pending: got %h exp 0001", d); end
    endtask

    task automatic test_wrap_and_unmapped();
        logic [15:0] d;
        apply_reset();
        avl_write(6'h3F, 16'hFFFF);
        avl_read(6'h3F, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL unmapped_read: got %h exp 0000", d); end
        avl_read(6'h07, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL unmapped_ctrl: got %h exp 0000", d); end
        avl_read(6'h00, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL unmapped_shadow: got %h exp 0000", d); end
        for (int i = 0; i < 15; i++) run_frame();
        avl_read(6'h08, d);
        checks++; if (d !== 16'd15 || readdata_w !== 16'h000F) begin errors++; $display("FAIL frame_15: got %h/%h exp 000f/000f", d, readdata_w); end
        run_frame();
        avl_read(6'h08, d);
        checks++; if (d !== 16'd16 || readdata_w !== 16'h0000) begin errors++; $display("FAIL frame_wrap: got %h/%h exp 0010/0000", d, readdata_w); end
        checks++; if ({boundary_1, sprite1_x, sprite1_y, irq} !== 31'd0) begin errors++; $display("FAIL unmapped_no_state: got %h exp 0", {boundary_1, sprite1_x, sprite1_y, irq}); end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] d;
        avl_write(6'h00, 16'd5);
        avl_write(6'h07, 16'h0001);
        run_frame();
        checks++; if (boundary_1 !== 10'd5) begin errors++; $display("FAIL midrst_setup: got %0d exp 5", boundary_1); end
        avl_write(6'h00, 16'd9);
        avl_write(6'h07, 16'h0001);
        vcount = 10'd300;
        hcount = 11'd20;
        tick();
        reset = 1'b1;
        #2;
        checks++; if (boundary_1 !== 10'd0) begin errors++; $display("FAIL midrst_async: got %0d exp 0", boundary_1); end
        tick();
        reset = 1'b0;
        raster_idle();
        tick();
        avl_read(6'h08, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL midrst_frame0: got %h exp 0000", d); end
        run_frame();
        checks++; if (boundary_1 !== 10'd0) begin errors++; $display("FAIL midrst_no_commit: got %0d exp 0", boundary_1); end
        avl_read(6'h08, d);
        checks++; if (d !== 16'd1) begin errors++; $display("FAIL midrst_frame1: got %0d exp 1", d); end
        avl_read(6'h00, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL midrst_shadow: got %h exp 0000", d); end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_auto();
        test_irq();
        test_one_vb_per_frame();
        test_pending_on_vb();
        test_wrap_and_unmapped();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
